draw_hook_gen: RTL and testbench

Parametrised successor to the fixed hook drawer. It renders the rope as a line from a fixed anchor to a run-time length and angle, then renders the hook ring around the rope end, with an angular gap that wraps correctly through 0°. Output is one pixel per transfer on a valid/ready stream into the frame-buffer writer, with off-screen clipping and an erase mode. It sits between the game-state controller, which supplies `start`, `angle`, `length` and `erase`, and the VGA pixel writer.

---
 rtl/draw_hook_gen_if.sv | 19 +
 rtl/draw_hook_gen.sv | 181 ++++++++++++++++++
 tb/tb_draw_hook_gen.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/draw_hook_gen_if.sv
// Pixel stream from the hook renderer to the frame-buffer writer.
// Valid/ready handshake; one pixel per transfer.
interface draw_hook_gen_if;
    logic        pixel_valid;
    logic        pixel_ready;
    logic [8:0]  pixel_x;
    logic [7:0]  pixel_y;
    logic [11:0] pixel_color;

    modport master (
        output pixel_valid, pixel_x, pixel_y, pixel_color,
        input  pixel_ready
    );

    modport slave (
        input  pixel_valid, pixel_x, pixel_y, pixel_color,
        output pixel_ready
    );
endinterface

// File: rtl/draw_hook_gen.sv
// Rope-and-hook renderer: rope line from a fixed anchor, then a ring
// with an angular gap around the rope end, streamed with clipping.
module draw_hook_gen #(
    parameter int          ANCHOR_X = 160,
    parameter int          ANCHOR_Y = 45,
    parameter int          RADIUS   = 4,
    parameter int          GAP_DEG  = 40,
    parameter int          SCREEN_W = 320,
    parameter int          SCREEN_H = 240,
    parameter logic [11:0] FG_COLOR = 12'hBBB,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [8:0]        i_angle,
    input  logic [8:0]        i_length,
    input  logic              i_erase,
    draw_hook_gen_if.master   pix,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ROPE, S_HOOK, S_DONE
    } state_t;

    localparam logic [6:0]        GAP_K = 7'(GAP_DEG / 5);
    localparam logic signed [10:0] SW_S = 11'(SCREEN_W);
    localparam logic signed [10:0] SH_S = 11'(SCREEN_H);

    state_t r_state, w_next;

    logic [8:0]         r_len, r_n;
    logic [6:0]         r_idx, r_k;
    logic               r_erase;
    logic signed [10:0] r_cx, r_cy;

    logic [8:0]         w_ang_c, w_n, w_ctrig, w_strig;
    logic [6:0]         w_si, w_ci, w_d;
    logic [15:0]        w_px, w_py;
    logic [10:0]        w_ox_u, w_oy_u;
    logic signed [10:0] w_ox, w_oy, w_bx, w_by, w_x, w_y;
    logic               w_cand, w_vis, w_skip, w_valid, w_adv;

    function automatic logic [7:0] f_qlut(input logic [4:0] r);
        case (r)
            5'd0:    f_qlut = 8'd0;
            5'd1:    f_qlut = 8'd11;
            5'd2:    f_qlut = 8'd22;
            5'd3:    f_qlut = 8'd33;
            5'd4:    f_qlut = 8'd44;
            5'd5:    f_qlut = 8'd54;
            5'd6:    f_qlut = 8'd64;
            5'd7:    f_qlut = 8'd73;
            5'd8:    f_qlut = 8'd82;
            5'd9:    f_qlut = 8'd91;
            5'd10:   f_qlut = 8'd98;
            5'd11:   f_qlut = 8'd105;
            5'd12:   f_qlut = 8'd111;
            5'd13:   f_qlut = 8'd116;
            5'd14:   f_qlut = 8'd120;
            5'd15:   f_qlut = 8'd124;
            5'd16:   f_qlut = 8'd126;
            5'd17:   f_qlut = 8'd128;
            5'd18:   f_qlut = 8'd128;
            default: f_qlut = 8'd0;
        endcase
    endfunction

    // {sign, magnitude} of sin(5k deg), folded from the quarter-wave table
    function automatic logic [8:0] f_trig(input logic [6:0] k);
        logic [1:0] q;
        logic [4:0] r;
        if (k < 7'd18) begin
            q = 2'd0; r = 5'(k);
        end else if (k < 7'd36) begin
            q = 2'd1; r = 5'(k - 7'd18);
        end else if (k < 7'd54) begin
            q = 2'd2; r = 5'(k - 7'd36);
        end else begin
            q = 2'd3; r = 5'(k - 7'd54);
        end
        f_trig = {q[1], q[0] ? f_qlut(5'd18 - r) : f_qlut(r)};
    endfunction

    assign w_ang_c = (i_angle >= 9'd360) ? 9'd355 : i_angle;

    assign w_cand = (r_state == S_ROPE) || (r_state == S_HOOK);
    assign w_n    = (r_state == S_HOOK) ? 9'(RADIUS) : r_n;
    assign w_si   = (r_state == S_HOOK) ? r_k : r_idx;
    assign w_ci   = (w_si >= 7'd54) ? w_si - 7'd54 : w_si + 7'd18;

    assign w_ctrig = f_trig(w_ci);
    assign w_strig = f_trig(w_si);
    assign w_px    = {7'd0, w_n} * {8'd0, w_ctrig[7:0]};
    assign w_py    = {7'd0, w_n} * {8'd0, w_strig[7:0]};
    assign w_ox_u  = 11'(w_px >> 7);
    assign w_oy_u  = 11'(w_py >> 7);
    assign w_ox    = w_ctrig[8] ? -$signed(w_ox_u) : $signed(w_ox_u);
    assign w_oy    = w_strig[8] ? -$signed(w_oy_u) : $signed(w_oy_u);

    assign w_bx = (r_state == S_HOOK) ? r_cx : 11'(ANCHOR_X);
    assign w_by = (r_state == S_HOOK) ? r_cy : 11'(ANCHOR_Y);
    assign w_x  = w_bx + w_ox;
    assign w_y  = w_by + w_oy;

    assign w_vis = (w_x >= 11'sd0) && (w_x < SW_S) &&
                   (w_y >= 11'sd0) && (w_y < SH_S);

    // Gap test in 5-degree steps; modular distance handles wrap through 0
    assign w_d    = (r_k >= r_idx) ? r_k - r_idx : r_k + 7'd72 - r_idx;
    assign w_skip = (r_state == S_HOOK) && (w_d <= GAP_K);

    assign w_valid = w_cand && w_vis && !w_skip;
    assign w_adv   = !w_valid || pix.pixel_ready;

    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (i_start) w_next = S_LOAD;
            S_LOAD:  w_next = S_ROPE;
            S_ROPE:  if (w_adv && r_n == r_len) w_next = S_HOOK;
            S_HOOK:  if (w_adv && r_k == 7'd71) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy          = (r_state != S_IDLE);
        o_done          = (r_state == S_DONE);
        pix.pixel_valid = w_valid;
        pix.pixel_x     = w_valid ? w_x[8:0] : 9'd0;
        pix.pixel_y     = w_valid ? w_y[7:0] : 8'd0;
        pix.pixel_color = w_valid ? (r_erase ? BG_COLOR : FG_COLOR) : 12'd0;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_len   <= 9'd0;
            r_n     <= 9'd0;
            r_idx   <= 7'd0;
            r_k     <= 7'd0;
            r_erase <= 1'b0;
            r_cx    <= 11'sd0;
            r_cy    <= 11'sd0;
        end else begin
            unique case (r_state)
                S_LOAD: begin
                    r_len   <= i_length;
                    r_erase <= i_erase;
                    r_idx   <= 7'(w_ang_c / 9'd5);
                    r_n     <= 9'd0;
                    r_k     <= 7'd0;
                end
                S_ROPE: begin
                    if (w_adv) begin
                        if (r_n == r_len) begin
                            r_cx <= w_x;
                            r_cy <= w_y;
                        end else begin
                            r_n <= r_n + 9'd1;
                        end
                    end
                end
                S_HOOK: begin
                    if (w_adv && r_k != 7'd71) r_k <= r_k + 7'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_draw_hook_gen.sv
// Bench for draw_hook_gen: trig-based pixel model, random backpressure,
// stall stability, done timing, clipping, gap wrap and mid-draw reset.
module tb_draw_hook_gen;

    localparam int          AX  = 160;
    localparam int          AY  = 45;
    localparam int          RAD = 4;
    localparam int          GAP = 40;
    localparam int          SW  = 320;
    localparam int          SH  = 240;
    localparam logic [11:0] FG  = 12'hBBB;
    localparam logic [11:0] BG  = 12'h000;
    localparam real         PI  = 3.14159265358979;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       start  = 1'b0;
    logic       erase  = 1'b0;
    logic [8:0] angle  = 9'd0;
    logic [8:0] length = 9'd0;
    logic       busy;
    logic       done;

    draw_hook_gen_if pif();

    draw_hook_gen dut (
        .i_clock  (clk),
        .i_reset  (rst),
        .i_start  (start),
        .i_angle  (angle),
        .i_length (length),
        .i_erase  (erase),
        .pix      (pif),
        .o_busy   (busy),
        .o_done   (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [28:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offset along one axis: rounded 128*trig, scaled by n, truncated
    function automatic int off(input int n, input int deg, input bit use_cos);
        real v, av;
        int  mag, o;
        v   = use_cos ? $cos(deg * PI / 180.0) : $sin(deg * PI / 180.0);
        av  = (v < 0.0) ? -v : v;
        mag = $rtoi(128.0 * av + 0.5);
        o   = (n * mag) >>> 7;
        return (v < 0.0) ? -o : o;
    endfunction

    function automatic bit on_screen(input int x, input int y);
        return (x >= 0) && (x < SW) && (y >= 0) && (y < SH);
    endfunction

    function automatic void build(input int ang, input int len, input bit er);
        int a5, x, y, cx, cy;
        logic [11:0] col;
        exp_q.delete();
        cx  = 0;
        cy  = 0;
        a5  = (((ang >= 360) ? 355 : ang) / 5) * 5;
        col = er ? BG : FG;
        for (int n = 0; n <= len; n++) begin
            x = AX + off(n, a5, 1'b1);
            y = AY + off(n, a5, 1'b0);
            if (n == len) begin
                cx = x;
                cy = y;
            end
            if (on_screen(x, y)) exp_q.push_back({x[8:0], y[7:0], col});
        end
        for (int a = 0; a < 360; a += 5) begin
            if (((a - a5 + 360) % 360) > GAP) begin
                x = cx + off(RAD, a, 1'b1);
                y = cy + off(RAD, a, 1'b0);
                if (on_screen(x, y)) exp_q.push_back({x[8:0], y[7:0], col});
            end
        end
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(pif.pixel_valid), 32'd0);
        chk({tag, "_x"}, 32'(pif.pixel_x), 32'd0);
        chk({tag, "_y"}, 32'(pif.pixel_y), 32'd0);
        chk({tag, "_color"}, 32'(pif.pixel_color), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // mode 0: ready high, 1: random ready, 2: fixed stall windows
    task automatic run_draw(input int ang, input int len, input bit er,
                            input int mode, input int abort_at);
        int          e;
        bit          finished, prev_stall, rdy;
        logic [28:0] cur, prev, ex;
        build(ang, len, er);
        @(negedge clk);
        angle  = 9'(ang);
        length = 9'(len);
        erase  = er;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_valid", 32'(pif.pixel_valid), 32'd0);
        e = 0;
        finished   = 1'b0;
        prev_stall = 1'b0;
        prev       = '0;
        while (!finished) begin
            @(negedge clk);
            e++;
            start  = 1'($urandom_range(0, 1));
            angle  = 9'($urandom);
            length = 9'($urandom);
            erase  = 1'($urandom);
            case (mode)
                1:       rdy = ($urandom_range(0, 3) != 0);
                2:       rdy = !((e >= 4 && e <= 8) || (e >= 40 && e <= 42));
                default: rdy = 1'b1;
            endcase
            pif.pixel_ready = rdy;
            cur = {pif.pixel_x, pif.pixel_y, pif.pixel_color};
            if (prev_stall) begin
                chk("stall_valid", 32'(pif.pixel_valid), 32'd1);
                chk("stall_data", 32'(cur), 32'(prev));
            end
            if (abort_at != 0 && e == abort_at) begin
                chk("abort_busy", 32'(busy), 32'd1);
                rst   = 1'b1;
                start = 1'b0;
                @(negedge clk);
                chk_idle_outputs("reset_mid");
                rst = 1'b0;
                @(negedge clk);
                chk("reset_stay_idle", 32'(busy), 32'd0);
                finished = 1'b1;
            end else if (done) begin
                start = 1'b0;
                chk("done_busy", 32'(busy), 32'd1);
                chk("done_remaining", 32'(exp_q.size()), 32'd0);
                if (mode == 0) chk("done_cycle", 32'(e), 32'(len + 74));
                finished = 1'b1;
                @(negedge clk);
                chk("after_done_pulse", 32'(done), 32'd0);
                chk("after_done_busy", 32'(busy), 32'd0);
            end else begin
                chk("run_busy", 32'(busy), 32'd1);
                if (pif.pixel_valid && rdy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $error("FAIL extra_pixel: observed %0h expected none", cur);
                    end else begin
                        ex = exp_q.pop_front();
                        chk("pixel", 32'(cur), 32'(ex));
                    end
                end
                if (e > 4000) begin
                    checks++;
                    failures++;
                    $error("FAIL timeout: observed no done after %0d cycles expected %0d",
                           e, len + 74);
                    finished = 1'b1;
                end
            end
            prev_stall = pif.pixel_valid && !rdy;
            prev       = cur;
        end
        pif.pixel_ready = 1'b1;
    endtask

    initial begin
        pif.pixel_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;

        run_draw(0, 10, 1'b0, 0, 0);
        run_draw(90, 3, 1'b0, 0, 0);
        run_draw(340, 10, 1'b0, 0, 0);
        run_draw(180, 200, 1'b0, 0, 0);
        run_draw(0, 10, 1'b1, 2, 0);
        run_draw(45, 20, 1'b0, 0, 40);
        run_draw(45, 20, 1'b0, 0, 0);
        run_draw(400, 15, 1'b0, 1, 0);
        run_draw(270, 0, 1'b0, 0, 0);
        run_draw(5, 311, 1'b0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            run_draw(int'($urandom_range(0, 511)), int'($urandom_range(0, 300)),
                     1'($urandom_range(0, 1)), 1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
